ni_tx_arbiter: RTL
==================

// Module: ni_tx_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter sharing one NoC injection port of the network interface among
//  N_REQ flit sources. A packet (HEAD..TAIL) is never interleaved with another; back-to-back packets
//  from different sources stream with no bubble. Sits between the APB-side packetisers and NI i_flit.
// PARAMETERS
//  N_REQ        4    number of requesters (>=2)
//  FLIT_W       16   flit width; type field = flit[FLIT_W-1:FLIT_W-2]
//  TIMEOUT_CYC  256  stall limit used only with NI_ARB_TIMEOUT_EN (>=2)
// PORTS
//  clk          in   1             single clock, posedge
//  resetn       in   1             asynchronous, active-low reset
//  req_flit     in   N_REQ*FLIT_W  flit of requester i at [i*FLIT_W +: FLIT_W]
//  req_valid    in   N_REQ         requester i presents a flit
//  req_ready    out  N_REQ         flit of requester i accepted this cycle (valid&ready)
//  o_flit       out  FLIT_W        registered flit to NoC
//  valid_out    out  1             o_flit valid
//  noc_ready    in   1             NoC accepts o_flit when valid_out&noc_ready
//  grant_id     out  $clog2(N_REQ) current/last granted requester
//  busy         out  1             high while locked mid-packet (state != IDLE)
//  err_timeout  out  1             1-cycle pulse on forced packet abort
// BEHAVIOUR
//  - Flit types (ni_pkg): 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
//  - Reset: o_flit=0, valid_out=0, grant_id=0, busy=0, err_timeout=0, rr pointer=0, state=IDLE;
//    req_ready is combinational and forced 0 while resetn=0. Reset mid-packet drops the packet silently.
//  - slot_free = !valid_out | noc_ready (comb path noc_ready->req_ready is intended).
//  - IDLE: winner = first i with req_valid[i], searching from rr pointer upward modulo N_REQ.
//    If winner & slot_free: req_ready[winner]=1, flit loaded to o_flit next edge, grant_id<=winner.
//    HEAD_TAIL -> stay IDLE, pointer<=winner+1; any other type -> PKT (lock on winner), busy<=1.
//  - PKT: only req_ready[grant_id] may assert (= req_valid[grant_id] & slot_free); other requesters
//    wait. Accepting TAIL -> IDLE, pointer<=grant_id+1, busy<=0. Requesters must start with HEAD;
//    type of first flit is trusted, no check.
//  - Output reg: loads on any accept; valid_out cleared when consumed with no new accept. Holds
//    o_flit stable while valid_out & !noc_ready.
//  - Latency: accept at edge N -> o_flit valid from N+1. Throughput 1 flit/cycle sustained.
//  - Pointer wraps N_REQ-1 -> 0. Only one req_ready bit high in any cycle.
// CONFIGURATION
//  NI_ARB_TIMEOUT_EN defined: in PKT, stall counter (width $clog2(TIMEOUT_CYC+1)) increments each
//   cycle req_valid[grant_id]=0, clears on accept. At TIMEOUT_CYC -> DRAIN: when slot_free inject
//   {TAIL, NI_ABORT_PAYLOAD=all-ones}, pulse err_timeout, pointer<=grant_id+1, -> IDLE. Late flits
//   from the aborted requester then compete as new packets.
//  Not defined: no counter, no DRAIN state, lock held indefinitely, err_timeout tied 0.
// STRUCTURE
//  ni_pkg: flit_type_e, NI_FLIT_TYPE_W, NI_ABORT_PAYLOAD, arb_state_e {IDLE,PKT,DRAIN}.
//  Sub-module ni_rr_arbiter: comb rotate-priority select (req vector, pointer -> one-hot, index).
//  Pointer, FSM, output register and timeout counter live in ni_tx_arbiter.
// TESTING
//  1 Reset: resetn=0 with all req_valid=1 -> req_ready=0, valid_out=0; release -> req0 granted first.
//  2 RR: req0..3 each HEAD_TAIL 0xC00i held valid, noc_ready=1 -> o_flit order 0,1,2,3,0 with
//    no bubbles.
//  3 Atomicity: req1 HEAD,BODY,BODY,TAIL while req2 valid -> all 4 req1 flits contiguous, req2
//    HEAD follows the TAIL on the next cycle.
//  4 Backpressure: noc_ready=0 for 5 cycles mid-packet -> o_flit stable, req_ready=0, no loss or
//    duplication.
//  5 Timeout (macro on, TIMEOUT_CYC=8): req0 HEAD then idle -> after 8 stall cycles o_flit=16'hBFFF,
//    err_timeout 1 cycle, req1 granted next.
//  6 Reset mid-packet: assert resetn after BODY -> all outputs reset values, next packet arbitrated
//    from pointer 0.

Source files
------------

// File: rtl/ni_pkg.sv
// -----------------------------------------------------------------------------
// ni_pkg
// Shared types and constants for the network-interface transmit path.
//   flit_type_e       : 2-bit flit type carried in the top bits of every flit
//   NI_FLIT_TYPE_W    : width of that type field
//   NI_ABORT_PAYLOAD  : all-ones payload used for the forced TAIL of an
//                       aborted packet (sliced to the flit payload width)
//   arb_state_e       : packet-lock state of the injection-port arbiter
// -----------------------------------------------------------------------------
package ni_pkg;

    localparam int NI_FLIT_TYPE_W = 2;

    typedef enum logic [NI_FLIT_TYPE_W-1:0] {
        FT_BODY      = 2'b00,
        FT_HEAD      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_e;

    // Wide enough for any practical flit; users take the low payload bits.
    localparam int                            NI_ABORT_PAYLOAD_W = 64;
    localparam logic [NI_ABORT_PAYLOAD_W-1:0] NI_ABORT_PAYLOAD   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ni_rr_arbiter.sv
// -----------------------------------------------------------------------------
// ni_rr_arbiter
// Purely combinational rotate-priority selector. The search starts at `ptr`
// and walks upward modulo N_REQ; the first asserted request wins.
// Ports:
//   req     in  N_REQ   request vector
//   ptr     in  IDX_W   highest-priority requester this cycle
//   gnt     out N_REQ   one-hot grant (all zero when no request)
//   gnt_idx out IDX_W   index of the granted requester
//   gnt_any out 1       at least one request present
// -----------------------------------------------------------------------------
module ni_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            // gnt_any doubles as the "already found" flag, so only the first
            // hit after the pointer is taken.
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ni_tx_arbiter.sv
// -----------------------------------------------------------------------------
// ni_tx_arbiter
// Packet-atomic round-robin arbiter sharing one NoC injection port among
// N_REQ flit sources. Once a HEAD is accepted the port is locked to that
// source until its TAIL; single-flit (HEAD_TAIL) packets never lock. Output
// is a one-stage register that streams one flit per cycle without bubbles.
//
// Optional feature (compile-time macro NI_ARB_TIMEOUT_EN): a locked source
// that stops presenting flits for TIMEOUT_CYC cycles has its packet closed
// with an injected {TAIL, all-ones} flit and err_timeout pulses for a cycle.
// Without the macro the lock is held indefinitely and err_timeout is 0.
//
// Ports:
//   clk          in   1              clock, rising edge
//   resetn       in   1              asynchronous active-low reset
//   req_flit     in   N_REQ*FLIT_W   flit of requester i at [i*FLIT_W +: FLIT_W]
//   req_valid    in   N_REQ          requester i presents a flit
//   req_ready    out  N_REQ          requester i's flit accepted this cycle
//   o_flit       out  FLIT_W         registered flit to the NoC
//   valid_out    out  1              o_flit valid
//   noc_ready    in   1              NoC takes o_flit when valid_out & noc_ready
//   grant_id     out  clog2(N_REQ)   current / last granted requester
//   busy         out  1              locked mid-packet (state != IDLE)
//   err_timeout  out  1              one-cycle pulse on a forced packet abort
// -----------------------------------------------------------------------------
module ni_tx_arbiter
    import ni_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int FLIT_W      = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_REQ*FLIT_W-1:0]   req_flit,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    output logic [FLIT_W-1:0]         o_flit,
    output logic                      valid_out,
    input  logic                      noc_ready,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [FLIT_W-1:0] flit_q,  flit_d;
    logic              valid_q, valid_d;

`ifdef NI_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q,   err_d;
`endif

    logic              slot_free;
    logic [N_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [N_REQ-1:0]  ready_c;
    logic [FLIT_W-1:0] win_flit;
    logic [FLIT_W-1:0] grant_flit;

    function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] f);
        return flit_type_e'(f[FLIT_W-1 -: NI_FLIT_TYPE_W]);
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    ni_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // The output register can take a new flit if it is empty or being drained
    // this very cycle; this makes noc_ready combinationally reach req_ready.
    assign slot_free  = !valid_q || noc_ready;
    assign win_flit   = req_flit[int'(arb_idx) * FLIT_W +: FLIT_W];
    assign grant_flit = req_flit[int'(grant_q) * FLIT_W +: FLIT_W];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        flit_d  = flit_q;
        valid_d = valid_q && !noc_ready;
        ready_c = '0;
`ifdef NI_ARB_TIMEOUT_EN
        stall_d = stall_q;
        err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
`ifdef NI_ARB_TIMEOUT_EN
                stall_d = '0;
`endif
                if (arb_any && slot_free) begin
                    ready_c = arb_gnt;
                    flit_d  = win_flit;
                    valid_d = 1'b1;
                    grant_d = arb_idx;
                    // Only a single-flit packet releases the port at once;
                    // any other first flit is trusted to be a HEAD and locks.
                    if (flit_type(win_flit) == FT_HEAD_TAIL) begin
                        ptr_d = next_ptr(arb_idx);
                    end else begin
                        state_d = PKT;
                    end
                end
            end

            PKT: begin
                if (req_valid[grant_q] && slot_free) begin
                    ready_c[grant_q] = 1'b1;
                    flit_d           = grant_flit;
                    valid_d          = 1'b1;
`ifdef NI_ARB_TIMEOUT_EN
                    stall_d          = '0;
`endif
                    if (flit_type(grant_flit) == FT_TAIL) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr(grant_q);
                    end
                end
`ifdef NI_ARB_TIMEOUT_EN
                // Only an absent flit counts as a stall; NoC backpressure
                // is not the source's fault.
                else if (!req_valid[grant_q]) begin
                    stall_d = stall_q + 1'b1;
                    if (stall_d == STALL_W'(TIMEOUT_CYC)) begin
                        state_d = DRAIN;
                    end
                end
`endif
            end

`ifdef NI_ARB_TIMEOUT_EN
            DRAIN: begin
                if (slot_free) begin
                    flit_d  = {FT_TAIL, NI_ABORT_PAYLOAD[FLIT_W-NI_FLIT_TYPE_W-1:0]};
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    stall_d = '0;
                    ptr_d   = next_ptr(grant_q);
                    state_d = IDLE;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            flit_q  <= '0;
            valid_q <= 1'b0;
`ifdef NI_ARB_TIMEOUT_EN
            stall_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            flit_q  <= flit_d;
            valid_q <= valid_d;
`ifdef NI_ARB_TIMEOUT_EN
            stall_q <= stall_d;
            err_q   <= err_d;
`endif
        end
    end

    // Handshake is suppressed while reset is held so no source pops a flit
    // that the arbiter is about to forget.
    assign req_ready = resetn ? ready_c : '0;
    assign o_flit    = flit_q;
    assign valid_out = valid_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);
`ifdef NI_ARB_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule
